// File: rtl/store_queue_drain_if.sv
// Store-queue bundle: AGU store ops, ROB commit/flush, data-memory write
// port and load forwarding lookup. The queue sits on the slave side.
interface store_queue_drain_if #(
  parameter int unsigned SQN_W = 7
);
  logic             IN_valid;
  logic             OUT_ready;
  logic [31:0]      IN_addr;
  logic [31:0]      IN_data;
  logic [3:0]       IN_wmask;
  logic [SQN_W-1:0] IN_sqN;
  logic [SQN_W-1:0] IN_commitSqN;
  logic             IN_flush;
  logic [SQN_W-1:0] IN_flushSqN;
  logic             OUT_memReq;
  logic [29:0]      OUT_memAddr;
  logic [31:0]      OUT_memData;
  logic [3:0]       OUT_memMask;
  logic             IN_memAck;
  logic [31:0]      IN_ldAddr;
  logic [SQN_W-1:0] IN_ldSqN;
  logic [31:0]      OUT_fwdData;
  logic [3:0]       OUT_fwdMask;
  logic             OUT_empty;

  modport slave (
    input  IN_valid, IN_addr, IN_data, IN_wmask, IN_sqN, IN_commitSqN,
           IN_flush, IN_flushSqN, IN_memAck, IN_ldAddr, IN_ldSqN,
    output OUT_ready, OUT_memReq, OUT_memAddr, OUT_memData, OUT_memMask,
           OUT_fwdData, OUT_fwdMask, OUT_empty
  );

  modport master (
    output IN_valid, IN_addr, IN_data, IN_wmask, IN_sqN, IN_commitSqN,
           IN_flush, IN_flushSqN, IN_memAck, IN_ldAddr, IN_ldSqN,
    input  OUT_ready, OUT_memReq, OUT_memAddr, OUT_memData, OUT_memMask,
           OUT_fwdData, OUT_fwdMask, OUT_empty
  );
endinterface

// File: rtl/store_queue_drain.sv
// Age-ordered store buffer: holds AGU store ops until the ROB commits them,
// drains committed stores to the data-memory write port (req/ack), forwards
// store bytes to younger loads and drops uncommitted entries on a flush.
module store_queue_drain #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SQN_W = 7
) (
  input logic clk,
  input logic rst,
  store_queue_drain_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, REQ} state_t;

  logic [DEPTH-1:0] valid_q, comm_q, valid_n, comm_n;
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [SQN_W-1:0] sqn_q  [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q, head_n, tail_n;
  logic [CNT_W-1:0] count_n;
  state_t           state_q, state_n;
  logic             push, pop, issue;
  logic             mem_req_q, ready_q, empty_q;
  logic [29:0]      mem_addr_q;
  logic [31:0]      mem_data_q;
  logic [3:0]       mem_mask_q;
  logic [31:0]      fwd_data;
  logic [3:0]       fwd_mask;
  logic [PTR_W-1:0] fwd_idx;
  logic             unused_addr_bits;

  // Wrap-aware age test: a is older than or equal to b.
  function automatic logic older_eq(input logic [SQN_W-1:0] a,
                                    input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return d[SQN_W-1] || (d == '0);
  endfunction

  // Wrap-aware age test: a is strictly older than b.
  function automatic logic older(input logic [SQN_W-1:0] a,
                                 input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

  // Next-state: commit marking, drain decision, enqueue, flush, occupancy.
  // The tail is rebuilt from head + surviving count every cycle; since flush
  // only ever trims a contiguous young suffix this equals the plain
  // increment/decrement update when no flush is active.
  always_comb begin
    logic [SQN_W-1:0] sq;
    sq      = '0;
    valid_n = valid_q;
    comm_n  = comm_q;
    state_n = state_q;
    head_n  = head_q;
    pop     = 1'b0;
    issue   = 1'b0;
    push    = bus.IN_valid && ready_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && older_eq(sqn_q[i], bus.IN_commitSqN)) comm_n[i] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (valid_q[head_q] && comm_n[head_q]) begin
          if (mask_q[head_q] == '0) begin
            pop = 1'b1;
          end else begin
            issue   = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (bus.IN_memAck) begin
          pop     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (pop) begin
      valid_n[head_q] = 1'b0;
      comm_n[head_q]  = 1'b0;
      head_n          = head_q + PTR_W'(1);
    end

    if (push) begin
      valid_n[tail_q] = 1'b1;
      comm_n[tail_q]  = 1'b0;
    end

    if (bus.IN_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sq = (push && PTR_W'(i) == tail_q) ? bus.IN_sqN : sqn_q[i];
        if (valid_n[i] && !comm_n[i] && !older_eq(sq, bus.IN_flushSqN) &&
            !(state_q == REQ && PTR_W'(i) == head_q))
          valid_n[i] = 1'b0;
      end
    end

    count_n = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_n = count_n + CNT_W'(valid_n[i]);
    end
    tail_n = head_n + count_n[PTR_W-1:0];
  end

  // Control state, pointers and registered memory-port / status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      comm_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_mask_q <= '0;
      ready_q    <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      valid_q <= valid_n;
      comm_q  <= comm_n;
      head_q  <= head_n;
      tail_q  <= tail_n;
      state_q <= state_n;
      ready_q <= count_n < CNT_W'(DEPTH);
      empty_q <= count_n == '0;
      if (issue) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= addr_q[head_q];
        mem_data_q <= data_q[head_q];
        mem_mask_q <= mask_q[head_q];
      end else if (state_q == REQ && bus.IN_memAck) begin
        mem_req_q <= 1'b0;
      end
    end
  end

  // Entry payload storage; validity lives in valid_q so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.IN_addr[31:2];
      data_q[tail_q] <= bus.IN_data;
      mask_q[tail_q] <= bus.IN_wmask;
      sqn_q[tail_q]  <= bus.IN_sqN;
    end
  end

  // Store-to-load forwarding: walk oldest to youngest so younger stores win.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    fwd_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if (valid_q[fwd_idx] && addr_q[fwd_idx] == bus.IN_ldAddr[31:2] &&
          older(sqn_q[fwd_idx], bus.IN_ldSqN)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (mask_q[fwd_idx][b]) begin
            fwd_mask[b]        = 1'b1;
            fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign unused_addr_bits = ^{bus.IN_addr[1:0], bus.IN_ldAddr[1:0]};

  assign bus.OUT_ready   = ready_q;
  assign bus.OUT_empty   = empty_q;
  assign bus.OUT_memReq  = mem_req_q;
  assign bus.OUT_memAddr = mem_addr_q;
  assign bus.OUT_memData = mem_data_q;
  assign bus.OUT_memMask = mem_mask_q;
  assign bus.OUT_fwdData = fwd_data;
  assign bus.OUT_fwdMask = fwd_mask;
endmodule

// File: tb/tb_store_queue_drain.sv
// Directed bench for store_queue_drain with a write-expectation scoreboard.
module tb_store_queue_drain;
  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   ack_en = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_req = 0;
  wr_t  sb[$];

  store_queue_drain_if #(.SQN_W(7)) bus ();

  store_queue_drain #(.DEPTH(8), .SQN_W(7)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: compares each request against the scoreboard, then acks.
  always @(negedge clk) begin
    wr_t e;
    if (bus.IN_memAck) begin
      bus.IN_memAck = 1'b0;
    end else if (bus.OUT_memReq && ack_en && rst) begin
      n_req++;
      check("req_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("mem_addr", bus.OUT_memAddr, e.a);
        check("mem_data", bus.OUT_memData, e.d);
        check("mem_mask", bus.OUT_memMask, e.m);
      end
      bus.IN_memAck = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic [6:0] s, input bit exp_drain);
    bus.IN_valid = 1'b1;
    bus.IN_addr  = a;
    bus.IN_data  = d;
    bus.IN_wmask = m;
    bus.IN_sqN   = s;
    step();
    bus.IN_valid = 1'b0;
    if (exp_drain && m != 4'b0) sb.push_back('{a[31:2], d, m});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (sb.size() == 0) && bus.OUT_empty && !bus.OUT_memReq;
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_req(input string tag, input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = n_req >= target;
    end
    check(tag, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.IN_valid = 0; bus.IN_addr = '0; bus.IN_data = '0; bus.IN_wmask = '0;
    bus.IN_sqN = '0; bus.IN_commitSqN = '0; bus.IN_flush = 0; bus.IN_flushSqN = '0;
    bus.IN_memAck = 0; bus.IN_ldAddr = '0; bus.IN_ldSqN = '0;

    // Reset state
    repeat (3) step();
    check("rst_memreq", bus.OUT_memReq, 0);
    check("rst_ready", bus.OUT_ready, 1);
    check("rst_empty", bus.OUT_empty, 1);
    check("rst_memaddr", bus.OUT_memAddr, 0);
    check("rst_fwdmask", bus.OUT_fwdMask, 0);
    rst = 1'b1;
    step();

    // Commit gating: only sqN<=commit drains
    bus.IN_commitSqN = 7'd2;
    base = n_req;
    enq(32'h100, 32'hA0A0A0A0, 4'hF, 7'd3, 1);
    enq(32'h104, 32'hA1A1A1A1, 4'hF, 7'd4, 1);
    enq(32'h108, 32'hA2A2A2A2, 4'hF, 7'd5, 1);
    check("commit_nodrain", n_req - base, 0);
    bus.IN_commitSqN = 7'd4;
    repeat (20) step();
    check("commit_two_reqs", n_req - base, 2);
    check("commit_one_left", sb.size(), 1);
    check("commit_not_empty", bus.OUT_empty, 0);
    bus.IN_commitSqN = 7'd5;
    wait_idle("commit_drain_done", 40);
    check("commit_three_reqs", n_req - base, 3);

    // Fill to capacity, reject 9th, then accept after a pop
    bus.IN_commitSqN = 7'd9;
    base = n_req;
    for (int i = 0; i < 8; i++)
      enq(32'h300 + 32'(4 * i), $urandom, 4'hF, 7'(10 + i), 1);
    check("full_ready", bus.OUT_ready, 0);
    check("full_empty", bus.OUT_empty, 0);
    enq(32'h3F0, 32'hDEAD0009, 4'hF, 7'd18, 0);
    check("full_still_notready", bus.OUT_ready, 0);
    bus.IN_commitSqN = 7'd17;
    wait_req("full_first_req", base + 1, 20);
    step();
    check("full_ready_again", bus.OUT_ready, 1);
    enq(32'h3F0, 32'hBEEF0009, 4'hF, 7'd18, 1);
    bus.IN_commitSqN = 7'd18;
    wait_idle("full_drain_done", 100);
    check("full_nine_reqs", n_req - base, 9);

    // Flush of uncommitted young suffix, same-cycle enqueue dropped
    bus.IN_commitSqN = 7'd9;
    base = n_req;
    for (int i = 0; i < 4; i++)
      enq(32'h400 + 32'(4 * i), 32'h40000000 + 32'(i), 4'hF, 7'(10 + i), (i < 2));
    bus.IN_commitSqN = 7'd10;
    bus.IN_flush     = 1'b1;
    bus.IN_flushSqN  = 7'd11;
    bus.IN_valid     = 1'b1;
    bus.IN_addr      = 32'h4F0;
    bus.IN_data      = 32'h14141414;
    bus.IN_wmask     = 4'hF;
    bus.IN_sqN       = 7'd14;
    step();
    bus.IN_flush = 1'b0;
    bus.IN_valid = 1'b0;
    bus.IN_ldAddr = 32'h40C;
    bus.IN_ldSqN  = 7'd20;
    #1;
    check("flush_fwd_gone", bus.OUT_fwdMask, 0);
    bus.IN_ldAddr = 32'h404;
    #1;
    check("flush_fwd_survivor", bus.OUT_fwdData, 32'h40000001);
    enq(32'h500, 32'h12121212, 4'hF, 7'd12, 1);
    repeat (15) step();
    check("flush_head_drained", n_req - base, 1);
    bus.IN_commitSqN = 7'd14;
    wait_idle("flush_drain_done", 60);
    check("flush_total_reqs", n_req - base, 3);

    // Forwarding, youngest older store wins per lane
    bus.IN_commitSqN = 7'd4;
    enq(32'h200, 32'h0000BBAA, 4'b0011, 7'd5, 1);
    enq(32'h200, 32'h0000CC00, 4'b0010, 7'd6, 1);
    bus.IN_ldAddr = 32'h200;
    bus.IN_ldSqN  = 7'd7;
    #1;
    check("fwd7_mask", bus.OUT_fwdMask, 4'b0011);
    check("fwd7_data", bus.OUT_fwdData, 32'h0000CCAA);
    bus.IN_ldSqN = 7'd6;
    #1;
    check("fwd6_mask", bus.OUT_fwdMask, 4'b0011);
    check("fwd6_data", bus.OUT_fwdData, 32'h0000BBAA);
    bus.IN_ldSqN = 7'd5;
    #1;
    check("fwd5_mask", bus.OUT_fwdMask, 4'b0000);
    check("fwd5_data", bus.OUT_fwdData, 32'h0);
    bus.IN_ldAddr = 32'h204;
    bus.IN_ldSqN  = 7'd7;
    #1;
    check("fwd_other_addr", bus.OUT_fwdMask, 4'b0000);
    bus.IN_commitSqN = 7'd6;
    wait_idle("fwd_drain_done", 40);

    // sqN wrap-around
    bus.IN_commitSqN = 7'd125;
    base = n_req;
    enq(32'h600, 32'h60606060, 4'hF, 7'd126, 1);
    enq(32'h604, 32'h61616161, 4'hF, 7'd127, 1);
    enq(32'h608, 32'h62626262, 4'hF, 7'd0, 1);
    repeat (5) step();
    check("wrap_held", n_req - base, 0);
    bus.IN_commitSqN = 7'd0;
    wait_idle("wrap_drain_done", 40);
    check("wrap_three_reqs", n_req - base, 3);

    // Fence entry pops without a request
    base = n_req;
    enq(32'h6F0, 32'hFFFFFFFF, 4'h0, 7'd1, 0);
    enq(32'h700, 32'h70707070, 4'hF, 7'd2, 1);
    bus.IN_commitSqN = 7'd2;
    wait_idle("fence_drain_done", 40);
    check("fence_one_req", n_req - base, 1);

    // Asynchronous reset in the middle of a request
    ack_en = 1'b0;
    enq(32'h800, 32'h80808080, 4'hF, 7'd3, 0);
    bus.IN_commitSqN = 7'd3;
    repeat (3) step();
    check("midreq_memreq", bus.OUT_memReq, 1);
    check("midreq_addr", bus.OUT_memAddr, 30'h200);
    #2;
    rst = 1'b0;
    #1;
    check("async_memreq", bus.OUT_memReq, 0);
    check("async_empty", bus.OUT_empty, 1);
    check("async_ready", bus.OUT_ready, 1);
    step();
    rst = 1'b1;
    ack_en = 1'b1;
    base = n_req;
    enq(32'h900, 32'h90909090, 4'hF, 7'd4, 1);
    bus.IN_commitSqN = 7'd4;
    wait_idle("post_reset_drain", 40);
    check("post_reset_one_req", n_req - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
